// File: rtl/dct8_pkg.sv
// Shared definitions for the 8-point DCT datapath: block geometry, stage growth
// and the butterfly output word ordering consumed by the downstream stages.
package dct8_pkg;

    localparam int unsigned N            = 8;
    localparam int unsigned HALF_N       = N / 2;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned STAGE_GROWTH = 1;

    // Output word ordering: sums s0..s3 first, then differences d0..d3.
    localparam int unsigned WORD_SUM0  = 0;
    localparam int unsigned WORD_DIFF0 = HALF_N;

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } rd_state_e;

    // Word k uses x[k mod 4] as its first operand for both sums and differences.
    function automatic logic [IDX_W-1:0] word_op_a(input logic [IDX_W-1:0] k);
        return k & IDX_W'(HALF_N - 1);
    endfunction

    function automatic logic [IDX_W-1:0] word_op_b(input logic [IDX_W-1:0] k);
        return IDX_W'(N - 1) - word_op_a(k);
    endfunction

    function automatic logic word_is_diff(input logic [IDX_W-1:0] k);
        return k >= IDX_W'(WORD_DIFF0);
    endfunction

endpackage

// File: rtl/dct8_pingpong_buf.sv
// Two banks of eight samples: serial write with bank toggle, per-bank full flags,
// and a dual combinational read port for the butterfly operands.
module dct8_pingpong_buf
    import dct8_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              fill_o,
    output logic              wr_bank_o,
    output logic [1:0]        full_o,
    input  logic              clr_en_i,
    input  logic              clr_bank_i,
    input  logic              rd_bank_i,
    input  logic [IDX_W-1:0]  rd_idx_a_i,
    input  logic [IDX_W-1:0]  rd_idx_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o
);

    logic [DATA_W-1:0] mem_q [2][N];
    logic [IDX_W-1:0]  wr_cnt_q;
    logic              wr_bank_q;
    logic [1:0]        full_q, full_d;

    assign fill_o      = wr_en_i && (wr_cnt_q == IDX_W'(N - 1));
    assign wr_bank_o   = wr_bank_q;
    assign full_o      = full_q;
    assign rd_data_a_o = mem_q[rd_bank_i][rd_idx_a_i];
    assign rd_data_b_o = mem_q[rd_bank_i][rd_idx_b_i];

    always_comb begin
        full_d = full_q;
        if (clr_en_i) begin
            full_d[clr_bank_i] = 1'b0;
        end
        if (fill_o) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else begin
            full_q <= full_d;
            if (wr_en_i) begin
                mem_q[wr_bank_q][wr_cnt_q] <= wr_data_i;
                wr_cnt_q                   <= wr_cnt_q + IDX_W'(1);
                if (fill_o) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
        end
    end

    // A drain always takes exactly 8 cycles, so a bank is empty before it is refilled.
    assert property (@(posedge clk) disable iff (!rst_n) !(wr_en_i && full_q[wr_bank_q]))
        else $error("write into a bank that has not been drained");

endmodule

// File: rtl/dct8_input_butterfly.sv
// First DCT stage: collects blocks of 8 serial samples into a ping-pong buffer and
// streams the symmetric sums and differences, one registered word per cycle.
module dct8_input_butterfly
    import dct8_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = DATA_W + STAGE_GROWTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sample,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_sample,
    output logic              out_first,
    output logic              out_last
);

    rd_state_e         state_q;
    logic              rd_bank_q;
    logic [IDX_W-1:0]  rd_cnt_q;
    logic              out_valid_q, out_first_q, out_last_q;
    logic [OUT_W-1:0]  out_sample_q;

    logic              fill, wr_bank;
    logic [1:0]        full;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              issue, last_word, other_ready;
    logic signed [OUT_W-1:0] op_a, op_b, bfly;

    dct8_pingpong_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (in_valid),
        .wr_data_i   (in_sample),
        .fill_o      (fill),
        .wr_bank_o   (wr_bank),
        .full_o      (full),
        .clr_en_i    (last_word),
        .clr_bank_i  (rd_bank_q),
        .rd_bank_i   (rd_bank_q),
        .rd_idx_a_i  (word_op_a(rd_cnt_q)),
        .rd_idx_b_i  (word_op_b(rd_cnt_q)),
        .rd_data_a_o (rd_a),
        .rd_data_b_o (rd_b)
    );

    // Banks fill and drain in strict alternation, so only rd_bank_q needs checking in idle.
    assign issue       = (state_q == StStream) || full[rd_bank_q];
    assign last_word   = issue && (rd_cnt_q == IDX_W'(N - 1));
    assign other_ready = full[~rd_bank_q] || (fill && (wr_bank == ~rd_bank_q));

    always_comb begin
        op_a = OUT_W'($signed(rd_a));
        op_b = OUT_W'($signed(rd_b));
        bfly = word_is_diff(rd_cnt_q) ? (op_a - op_b) : (op_a + op_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_sample_q <= '0;
        end else begin
            out_valid_q <= issue;
            out_first_q <= issue && (rd_cnt_q == '0);
            out_last_q  <= last_word;
            if (issue) begin
                out_sample_q <= bfly;
                if (last_word) begin
                    rd_cnt_q  <= '0;
                    rd_bank_q <= ~rd_bank_q;
                    state_q   <= other_ready ? StStream : StIdle;
                end else begin
                    rd_cnt_q <= rd_cnt_q + IDX_W'(1);
                    state_q  <= StStream;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_first  = out_first_q;
    assign out_last   = out_last_q;
    assign out_sample = out_sample_q;

endmodule

// File: tb/tb_dct8_input_butterfly.sv
// Scoreboard bench for dct8_input_butterfly: directed blocks push hand-computed words
// with their due cycle; a negedge monitor pops and compares every presented word.
module tb_dct8_input_butterfly;

    typedef int vec8_t [8];
    typedef struct {
        logic signed [16:0] s;
        logic               f;
        logic               l;
        int                 cyc;
        int                 id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_sample;
    logic        out_valid;
    logic [16:0] out_sample;
    logic        out_first;
    logic        out_last;

    exp_t exp_q [$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    dct8_input_butterfly #(
        .DATA_W (16),
        .OUT_W  (17)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .out_first  (out_first),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got sample=%0d first=%0b last=%0b cyc=%0d, want none",
                         $signed(out_sample), out_first, out_last, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_sample !== e.s || out_first !== e.f || out_last !== e.l || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL word_blk%0d: got sample=%0d first=%0b last=%0b cyc=%0d, want sample=%0d first=%0b last=%0b cyc=%0d",
                             e.id, $signed(out_sample), out_first, out_last, cyc,
                             e.s, e.f, e.l, e.cyc);
                end
            end
        end
    end

    task automatic send_block(input vec8_t x, input vec8_t e, input bit gapped, input int id,
                              output int c8);
        c8 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_sample = 16'(x[i]);
            if (i == 7) begin
                c8 = cyc;
                for (int k = 0; k < 8; k++) begin
                    exp_t w;
                    w.s   = 17'(e[k]);
                    w.f   = (k == 0);
                    w.l   = (k == 7);
                    w.cyc = c8 + 2 + k;
                    w.id  = id;
                    exp_q.push_back(w);
                end
            end
            if (gapped) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_%s: got %0d words outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (out_valid !== 1'b0 || out_sample !== 17'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got valid=%0b sample=%0d first=%0b last=%0b, want all 0",
                     name, out_valid, $signed(out_sample), out_first, out_last);
        end
    endtask

    // Called just after a negedge; the monitor has already sampled that edge.
    task automatic pulse_reset(input string name);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check_zero(name);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec8_t b1, e1, bx, ex, b2, e2, b3, e3;
        int c;
        b1 = '{1, 2, 3, 4, 5, 6, 7, 8};
        e1 = '{9, 9, 9, 9, -7, -5, -3, -1};
        bx = '{32767, -32768, 0, 0, 0, 0, 32767, 32767};
        ex = '{65534, -1, 0, 0, 0, -65535, 0, 0};
        b2 = '{10, 20, 30, 40, 50, 60, 70, 80};
        e2 = '{90, 90, 90, 90, -70, -50, -30, -10};
        b3 = '{-5, -5, -5, -5, -5, -5, -5, -5};
        e3 = '{-10, -10, -10, -10, 0, 0, 0, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;

        send_block(b1, e1, 1'b0, 1, c);
        go_idle();
        drain("single");

        send_block(bx, ex, 1'b0, 2, c);
        go_idle();
        drain("extremes");

        send_block(b1, e1, 1'b0, 3, c);
        send_block(b2, e2, 1'b0, 4, c);
        send_block(b3, e3, 1'b0, 5, c);
        go_idle();
        drain("continuous");

        send_block(b1, e1, 1'b1, 6, c);
        go_idle();
        drain("gapped");

        // Reset with a partial block collected.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_sample = 16'(b2[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        pulse_reset("reset_partial");
        send_block(b1, e1, 1'b0, 7, c);
        go_idle();
        drain("after_partial_reset");

        // Reset while word 3 of a block is on the output.
        send_block(b1, e1, 1'b0, 8, c);
        go_idle();
        while (cyc < c + 5) @(negedge clk);
        pulse_reset("reset_streaming");
        send_block(b1, e1, 1'b0, 9, c);
        go_idle();
        drain("after_stream_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dct8_input_butterfly.md
Name: dct8_input_butterfly

Overview:
- First stage of the 8-point DCT datapath. Receives one sample per valid cycle in serial form and groups the samples into blocks of 8.
- For each block it computes the symmetric even/odd butterfly: sums x[i]+x[7-i] and differences x[i]-x[7-i].
- Streams the 8 butterfly results serially to the downstream rotation stages.
- Ping-pong buffered, so it accepts the next block while the previous one is being streamed out. Continuous input never stalls.

Parameters:
- DATA_W, 16, input sample width (signed two's complement).
- OUT_W, DATA_W+1, output width. Fixed at one bit of growth; must be ≥ DATA_W+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_sample is valid this cycle. The sample is accepted on the clock edge, unconditionally (no backpressure).
- in_sample  input  DATA_W  signed input sample. The first accepted sample of a block is x[0].
- out_valid  output  1  out_sample is valid.
- out_sample  output  OUT_W  signed butterfly result.
- out_first  output  1  high together with out_valid on word 0 of a block.
- out_last  output  1  high together with out_valid on word 7 of a block.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_sample=0, out_first=0, out_last=0.
  - Write counter=0, write bank=0, read counter=0, rd_active=0, full flags cleared.
  - Any partially collected block, or block being streamed, is discarded.
- Storage: two banks of 8 x DATA_W registers (bank0, bank1).
- Write side:
  - Each cycle with in_valid=1, the sample goes to bank[wr_bank][wr_cnt] and wr_cnt increments.
  - When wr_cnt==7 is accepted: wr_cnt wraps to 0, wr_bank toggles, and that bank is marked full.
  - Gaps in in_valid are allowed anywhere within a block.
- Read side:
  - States are IDLE and STREAM.
  - IDLE -> STREAM on the cycle after a bank becomes full (rd_bank = that bank, rd_cnt = 0).
  - In STREAM, one registered output word is produced per cycle:
    - k = 0..3: out_sample = sext(x[k]) + sext(x[7-k]).
    - k = 4..7: out_sample = sext(x[k-4]) - sext(x[11-k]). Words 4..7 are therefore d0..d3 = x[0]-x[7], x[1]-x[6], x[2]-x[5], x[3]-x[4].
  - Both operands are sign-extended to OUT_W before add/sub. No saturation is needed, because the result is exact in DATA_W+1 bits.
  - After word 7: the bank's full flag is cleared. If the other bank is full, streaming continues with its word 0 on the next cycle, back-to-back with no bubble; otherwise the state returns to IDLE.
- Latency: when the 8th sample is accepted at edge T, out_valid/out_first with word 0 are registered at edge T+1. Word 7 appears at edge T+8.
- Simultaneous events: a bank-full event on the same cycle that word 7 of the other bank is issued is handled as back-to-back streaming. Fill and drain of different banks proceed concurrently.
- Overrun cannot occur:
  - A fill needs ≥8 accepts and a drain takes exactly 8 cycles.
  - Therefore a bank is always drained before it is refilled.
  - An assertion checks that no write ever targets a full bank.
- Outside STREAM: out_valid=0, out_first=0, out_last=0. out_sample holds its last value.

Decomposition:
- Shared package dct8_pkg holds:
  - The block length constant N=8 and its index width 3.
  - The width-growth helper constant (stage growth = 1).
  - The output word ordering (indices of sums 0..3, diffs 4..7), which downstream stages also consume.
- One natural sub-module: dct8_pingpong_buf (two banks of 8 words, write pointer/bank toggle, full flags, read port). The butterfly add/sub and read FSM stay in the top.

Test Plan:
- Single block, in_sample = 1,2,3,4,5,6,7,8 on consecutive cycles -> expect out = 9,9,9,9,-7,-5,-3,-1.
  - Word 0 is registered at the edge after the 8th accept.
  - out_first on word 0 only; out_last on word 7 only.
- Extremes with DATA_W=16:
  - x[0]=x[7]=32767 gives word0=65534.
  - x[1]=-32768, x[6]=32767 gives word5=-65535.
  - No wrap in a 17-bit output.
- Continuous input of 3 blocks (1..8, then 10..80 step 10, then all -5) with in_valid held high -> 24 output words with no out_valid gap.
  - Block 2 outputs 90,90,90,90,-70,-50,-30,-10.
  - Block 3 outputs -10 x4, then 0 x4.
- Gapped input: in_valid toggles 1,0,1,0... with the 1..8 block -> same 8 results as the single-block case, starting the edge after the 8th accept.
- Reset mid-operation: assert rst_n=0 after 5 samples of block A, and again during word 3 of a streaming block.
  - All outputs return to 0 immediately.
  - The next full block 1..8 after release produces exactly the single-block result with no stale words.
